// File: rtl/thread_manager_pkg.sv
// Shared types and sizing for the thread manager and its launch FIFO.
package thread_manager_pkg;

  localparam int unsigned NUM_OF_STP = 4;
  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned TID_WIDTH  = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [TID_WIDTH-1:0]  tid;
  } tm_req_t;

  typedef enum logic [1:0] {
    TM_IDLE,
    TM_DISPATCH,
    TM_RUN,
    TM_REPORT
  } tm_slot_state_e;

endpackage

// File: rtl/thread_manager_fifo.sv
// Synchronous launch FIFO: power-of-two depth, push/pop/full/empty/count.
module tm_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/thread_manager.sv
// Queues host thread launches, dispatches them to idle stp pipelines and reports completions.
module thread_manager
  import thread_manager_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  tm_enable,
  input  logic                                  host_req_vld,
  input  logic [ADDR_WIDTH-1:0]                 host_req_pc,
  input  logic [TID_WIDTH-1:0]                  host_req_tid,
  output logic                                  host_req_ready,
  output logic [NUM_OF_STP-1:0]                 tm_req_vld,
  output tm_req_t [NUM_OF_STP-1:0]              tm_req,
  input  logic [NUM_OF_STP-1:0]                 tm_req_grant,
  input  logic [NUM_OF_STP-1:0]                 tm_rsp_vld,
  output logic [NUM_OF_STP-1:0]                 tm_rsp_ack,
  output logic                                  done_vld,
  output logic [TID_WIDTH-1:0]                  done_tid,
  output logic [$clog2(NUM_OF_STP+1)-1:0]       active_threads,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]      queue_count,
  output logic                                  err_unexpected_rsp
);

  localparam int unsigned IDX_W = (NUM_OF_STP > 1) ? $clog2(NUM_OF_STP) : 1;
  localparam int unsigned ACT_W = $clog2(NUM_OF_STP + 1);

  tm_slot_state_e          r_state     [NUM_OF_STP];
  tm_slot_state_e          w_state_nxt [NUM_OF_STP];
  tm_req_t [NUM_OF_STP-1:0] r_req;
  tm_req_t                 w_host_req;
  tm_req_t                 w_fifo_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_disp_any;
  logic [IDX_W-1:0]        w_disp_idx;
  logic                    w_cmp_any;
  logic [IDX_W-1:0]        w_cmp_idx;
  logic [NUM_OF_STP-1:0]   w_unexp;
  logic [ACT_W-1:0]        w_active_nxt;
  logic                    r_done_vld;
  logic [TID_WIDTH-1:0]    r_done_tid;
  logic [ACT_W-1:0]        r_active;
  logic                    r_err;

  assign w_host_req     = {host_req_pc, host_req_tid};
  assign w_push         = host_req_vld && !w_fifo_full;
  assign w_pop          = tm_enable && !w_fifo_empty && w_disp_any;
  assign host_req_ready = !w_fifo_full;

  tm_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(tm_req_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_host_req),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (queue_count)
  );

  // Fixed-priority pickers: lowest-index IDLE slot and lowest-index finished RUN slot.
  always_comb begin
    w_disp_any = 1'b0;
    w_disp_idx = '0;
    w_cmp_any  = 1'b0;
    w_cmp_idx  = '0;
    for (int i = 0; i < NUM_OF_STP; i++) begin
      if (!w_disp_any && r_state[i] == TM_IDLE) begin
        w_disp_any = 1'b1;
        w_disp_idx = IDX_W'(i);
      end
      if (!w_cmp_any && r_state[i] == TM_RUN && tm_rsp_vld[i]) begin
        w_cmp_any = 1'b1;
        w_cmp_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    tm_rsp_ack   = '0;
    w_unexp      = '0;
    w_active_nxt = '0;
    for (int i = 0; i < NUM_OF_STP; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        TM_IDLE:     if (w_pop && w_disp_idx == IDX_W'(i)) w_state_nxt[i] = TM_DISPATCH;
        TM_DISPATCH: if (tm_req_grant[i]) w_state_nxt[i] = TM_RUN;
        TM_RUN: begin
          if (w_cmp_any && w_cmp_idx == IDX_W'(i)) begin
            w_state_nxt[i] = TM_REPORT;
            tm_rsp_ack[i]  = 1'b1;
          end
        end
        TM_REPORT:   w_state_nxt[i] = TM_IDLE;
        default:     w_state_nxt[i] = TM_IDLE;
      endcase
      if (tm_rsp_vld[i] && r_state[i] != TM_RUN) w_unexp[i] = 1'b1;
      if (w_state_nxt[i] != TM_IDLE) w_active_nxt = w_active_nxt + ACT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_STP; i++) r_state[i] <= TM_IDLE;
      r_done_vld <= 1'b0;
      r_done_tid <= '0;
      r_active   <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OF_STP; i++) r_state[i] <= w_state_nxt[i];
      r_done_vld <= w_cmp_any;
      if (w_cmp_any) r_done_tid <= r_req[w_cmp_idx].tid;
      r_active   <= w_active_nxt;
      r_err      <= r_err | (|w_unexp);
    end
  end

  // Slot payload is captured at pop and held steady through DISPATCH/RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req <= '0;
    end else if (w_pop) begin
      r_req[w_disp_idx] <= w_fifo_head;
    end
  end

  always_comb begin
    tm_req_vld = '0;
    for (int i = 0; i < NUM_OF_STP; i++) tm_req_vld[i] = (r_state[i] == TM_DISPATCH);
  end

  assign tm_req             = r_req;
  assign done_vld           = r_done_vld;
  assign done_tid           = r_done_tid;
  assign active_threads     = r_active;
  assign err_unexpected_rsp = r_err;

endmodule
